// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, PC step, fetch FSM
// state encoding and the redirect-target alignment helper.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_redirect_mux.sv
// Redirect priority selector for the fetch unit: trap > jump > branch.
// The trap level exists only when FETCH_TRAP_EN is defined.
// The selected target is word-aligned before it leaves this block.
module fetch_redirect_mux
    import cpu_pkg::*;
(
`ifdef FETCH_TRAP_EN
    input  logic            i_trap_valid,
    input  logic [XLEN-1:0] i_trap_vector,
`endif
    input  logic            i_jump_valid,
    input  logic [XLEN-1:0] i_jump_target,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_branch_target,
    output logic            o_redir_valid,
    output logic [XLEN-1:0] o_redir_target
);

    // Pick the highest-priority active redirect and align its target.
    always_comb begin
        o_redir_valid  = 1'b0;
        o_redir_target = '0;
`ifdef FETCH_TRAP_EN
        if (i_trap_valid) begin
            o_redir_valid  = 1'b1;
            o_redir_target = align_pc(i_trap_vector);
        end else
`endif
        if (i_jump_valid) begin
            o_redir_valid  = 1'b1;
            o_redir_target = align_pc(i_jump_target);
        end else if (i_branch_taken) begin
            o_redir_valid  = 1'b1;
            o_redir_target = align_pc(i_branch_target);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding IMEM request at a time,
// a single-entry holding register towards decode, redirect handling in
// every state and a sticky timeout flag for slow memory responses.
// Optional trap redirect port pair enabled by defining FETCH_TRAP_EN.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          IMEM_MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
`ifdef FETCH_TRAP_EN
    input  logic        trap_valid,
    input  logic [31:0] trap_vector,
`endif
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] pc_curr,
    output logic        fetch_err
);

    localparam int              CNT_W   = $clog2(IMEM_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(IMEM_MAX_WAIT);

    fetch_state_t      r_state;
    logic [XLEN-1:0]   r_pc;
    logic              r_req;
    logic [XLEN-1:0]   r_addr;
    logic              r_if_valid;
    logic [XLEN-1:0]   r_if_instr;
    logic [XLEN-1:0]   r_if_pc;
    logic              r_err;
    logic              r_drop;
    logic [CNT_W-1:0]  r_wait_cnt;

    logic              w_redir_valid;
    logic [XLEN-1:0]   w_redir_target;
    logic              w_handshake;
    logic [XLEN-1:0]   w_pc_inc;
    logic [CNT_W-1:0]  w_cnt_next;

    fetch_redirect_mux u_redirect_mux (
`ifdef FETCH_TRAP_EN
        .i_trap_valid    (trap_valid),
        .i_trap_vector   (trap_vector),
`endif
        .i_jump_valid    (jump_valid),
        .i_jump_target   (jump_target),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .o_redir_valid   (w_redir_valid),
        .o_redir_target  (w_redir_target)
    );

    assign w_handshake = r_if_valid && if_ready;
    assign w_pc_inc    = r_pc + PC_INC;
    // The wait counter saturates so the flag logic never wraps back.
    assign w_cnt_next  = (r_wait_cnt == MAX_CNT) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);

    // Fetch FSM: request issue, response capture, decode handshake and redirects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
            r_err      <= 1'b0;
            r_drop     <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                    if (w_redir_valid) begin
                        r_pc   <= w_redir_target;
                        r_addr <= w_redir_target;
                    end else begin
                        r_addr <= r_pc;
                    end
                end
                S_REQ: begin
                    if (imem_gnt) begin
                        // Old address was accepted; a redirect now must drop its data.
                        r_state    <= S_WAIT;
                        r_req      <= 1'b0;
                        r_wait_cnt <= '0;
                        if (w_redir_valid) begin
                            r_pc   <= w_redir_target;
                            r_drop <= 1'b1;
                        end
                    end else if (w_redir_valid) begin
                        r_pc   <= w_redir_target;
                        r_addr <= w_redir_target;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_drop || w_redir_valid) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
                            if (w_redir_valid) begin
                                r_pc   <= w_redir_target;
                                r_addr <= w_redir_target;
                            end else begin
                                r_addr <= r_pc;
                            end
                        end else begin
                            r_if_valid <= 1'b1;
                            r_if_instr <= imem_rdata;
                            r_if_pc    <= r_addr;
                            r_state    <= S_HOLD;
                        end
                    end else begin
                        r_wait_cnt <= w_cnt_next;
                        if (w_cnt_next == MAX_CNT) begin
                            r_err <= 1'b1;
                        end
                        if (w_redir_valid) begin
                            r_pc   <= w_redir_target;
                            r_drop <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    // A redirect outranks the +4 step; any handshake this cycle still retires.
                    if (w_redir_valid) begin
                        r_if_valid <= 1'b0;
                        r_pc       <= w_redir_target;
                        r_addr     <= w_redir_target;
                        r_req      <= 1'b1;
                        r_state    <= S_REQ;
                    end else if (w_handshake) begin
                        r_if_valid <= 1'b0;
                        r_pc       <= w_pc_inc;
                        r_addr     <= w_pc_inc;
                        r_req      <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;
    assign pc_curr   = r_pc;
    assign fetch_err = r_err;

endmodule
